// File: rtl/core_axi_rd_arbiter.sv
// Two-master AXI-lite read-channel arbiter. Master 0 is instruction fetch and
// master 1 is the load/store unit. One read is outstanding at a time. The
// granted master sees ARREADY and RVALID together in a single completion cycle.
// Optional feature: define ARB_ROUND_ROBIN_EN for round-robin tie-breaking.
// Without it, master 1 wins every tie.
module core_axi_rd_arbiter #(
    parameter int unsigned AXI_AWIDTH = 4,
    parameter int unsigned AXI_DWIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [AXI_AWIDTH-1:0] M0_ARADDR,
    input  logic                  M0_ARVALID,
    output logic                  M0_ARREADY,
    output logic [AXI_DWIDTH-1:0] M0_RDATA,
    output logic [1:0]            M0_RRESP,
    output logic                  M0_RVALID,
    input  logic                  M0_RREADY,
    input  logic [AXI_AWIDTH-1:0] M1_ARADDR,
    input  logic                  M1_ARVALID,
    output logic                  M1_ARREADY,
    output logic [AXI_DWIDTH-1:0] M1_RDATA,
    output logic [1:0]            M1_RRESP,
    output logic                  M1_RVALID,
    input  logic                  M1_RREADY,
    output logic [AXI_AWIDTH-1:0] S_ARADDR,
    output logic                  S_ARVALID,
    input  logic                  S_ARREADY,
    input  logic [AXI_DWIDTH-1:0] S_RDATA,
    input  logic [1:0]            S_RRESP,
    input  logic                  S_RVALID,
    output logic                  S_RREADY,
    output logic [1:0]            GRANT,
    output logic                  BUSY
);

    typedef enum logic [1:0] {StIdle, StAddr, StData, StResp} state_e;

    localparam logic [31:0] ResetData = 32'hDEADBEEF;

    state_e                  state_q;
    logic [1:0]              grant_q;
    logic [1:0]              strobe_q;   // per-master ARREADY/RVALID completion strobe
    logic [AXI_AWIDTH-1:0]   s_araddr_q;
    logic                    s_arvalid_q;
    logic                    s_rready_q;
    logic [AXI_DWIDTH-1:0]   rdata_q;
    logic [1:0]              rresp_q;
    logic                    pick_m1;
    logic                    resp_done;
`ifdef ARB_ROUND_ROBIN_EN
    logic                    last_q;     // 1: master 1 won the most recent grant
`endif

    // Winner selection in IDLE and RESP exit condition for the granted master.
    always_comb begin
        pick_m1 = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        pick_m1 = M1_ARVALID && (!M0_ARVALID || !last_q);
`else
        pick_m1 = M1_ARVALID;
`endif
        resp_done = (grant_q[0] && (M0_RREADY || !M0_ARVALID)) ||
                    (grant_q[1] && (M1_RREADY || !M1_ARVALID));
    end

    // Transaction FSM with registered slave-side and master-side handshakes.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StIdle;
            grant_q     <= 2'b00;
            strobe_q    <= 2'b00;
            s_araddr_q  <= '0;
            s_arvalid_q <= 1'b0;
            s_rready_q  <= 1'b0;
            rdata_q     <= AXI_DWIDTH'(ResetData);
            rresp_q     <= 2'b00;
`ifdef ARB_ROUND_ROBIN_EN
            last_q      <= 1'b1;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (M0_ARVALID || M1_ARVALID) begin
                        grant_q     <= pick_m1 ? 2'b10 : 2'b01;
                        s_araddr_q  <= pick_m1 ? M1_ARADDR : M0_ARADDR;
                        s_arvalid_q <= 1'b1;
                        state_q     <= StAddr;
`ifdef ARB_ROUND_ROBIN_EN
                        last_q      <= pick_m1;
`endif
                    end
                end
                StAddr: begin
                    if (S_ARREADY) begin
                        s_arvalid_q <= 1'b0;
                        s_rready_q  <= 1'b1;
                        state_q     <= StData;
                    end
                end
                StData: begin
                    // Slave read always completes, even if the master has gone away.
                    if (S_RVALID) begin
                        rdata_q    <= S_RDATA;
                        rresp_q    <= S_RRESP;
                        s_rready_q <= 1'b0;
                        strobe_q   <= grant_q;
                        state_q    <= StResp;
                    end
                end
                StResp: begin
                    if (resp_done) begin
                        grant_q  <= 2'b00;
                        strobe_q <= 2'b00;
                        state_q  <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign M0_ARREADY = strobe_q[0];
    assign M0_RVALID  = strobe_q[0];
    assign M1_ARREADY = strobe_q[1];
    assign M1_RVALID  = strobe_q[1];
    assign M0_RDATA   = rdata_q;
    assign M1_RDATA   = rdata_q;
    assign M0_RRESP   = rresp_q;
    assign M1_RRESP   = rresp_q;
    assign S_ARADDR   = s_araddr_q;
    assign S_ARVALID  = s_arvalid_q;
    assign S_RREADY   = s_rready_q;
    assign GRANT      = grant_q;
    assign BUSY       = (state_q != StIdle);

endmodule

// File: tb/tb_core_axi_rd_arbiter.sv
// Directed bench for core_axi_rd_arbiter. Inputs change and outputs are
// sampled on the falling clock edge. Expected values are hand-derived.
module tb_core_axi_rd_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic [3:0]  M0_ARADDR, M1_ARADDR, S_ARADDR;
    logic        M0_ARVALID, M1_ARVALID, M0_ARREADY, M1_ARREADY;
    logic [31:0] M0_RDATA, M1_RDATA, S_RDATA;
    logic [1:0]  M0_RRESP, M1_RRESP, S_RRESP, GRANT;
    logic        M0_RVALID, M1_RVALID, M0_RREADY, M1_RREADY;
    logic        S_ARVALID, S_ARREADY, S_RVALID, S_RREADY, BUSY;

    int n_err = 0;
    int n_chk = 0;

`ifdef ARB_ROUND_ROBIN_EN
    localparam logic [1:0] TieFirst = 2'b01;
`else
    localparam logic [1:0] TieFirst = 2'b10;
`endif
    localparam logic [1:0] TieSecond = 2'b10;

    core_axi_rd_arbiter #(.AXI_AWIDTH(4), .AXI_DWIDTH(32)) dut (
        .CLK(CLK), .RST(RST),
        .M0_ARADDR(M0_ARADDR), .M0_ARVALID(M0_ARVALID), .M0_ARREADY(M0_ARREADY),
        .M0_RDATA(M0_RDATA), .M0_RRESP(M0_RRESP), .M0_RVALID(M0_RVALID),
        .M0_RREADY(M0_RREADY),
        .M1_ARADDR(M1_ARADDR), .M1_ARVALID(M1_ARVALID), .M1_ARREADY(M1_ARREADY),
        .M1_RDATA(M1_RDATA), .M1_RRESP(M1_RRESP), .M1_RVALID(M1_RVALID),
        .M1_RREADY(M1_RREADY),
        .S_ARADDR(S_ARADDR), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
        .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RVALID(S_RVALID),
        .S_RREADY(S_RREADY), .GRANT(GRANT), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    initial begin
        RST = 1'b1;
        M0_ARADDR = '0; M1_ARADDR = '0; M0_ARVALID = 0; M1_ARVALID = 0;
        M0_RREADY = 0; M1_RREADY = 0;
        S_ARREADY = 0; S_RVALID = 0; S_RDATA = '0; S_RRESP = '0;
        tick(); tick();

        // Reset state.
        chk("rst_s_arvalid", 32'(S_ARVALID), 32'd0);
        chk("rst_s_rready", 32'(S_RREADY), 32'd0);
        chk("rst_s_araddr", 32'(S_ARADDR), 32'd0);
        chk("rst_grant", 32'(GRANT), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_rdata", M0_RDATA, 32'hDEADBEEF);
        chk("rst_rresp", 32'(M1_RRESP), 32'd0);
        chk("rst_m0_rvalid", 32'(M0_RVALID), 32'd0);
        chk("rst_m1_arready", 32'(M1_ARREADY), 32'd0);
        RST = 1'b0;

        // Single fetch, zero-wait slave: cycle 0 request.
        M0_ARADDR = 4'h4; M0_ARVALID = 1; M0_RREADY = 1;
        S_ARREADY = 1; S_RVALID = 1; S_RDATA = 32'h00500093; S_RRESP = 2'b00;
        tick(); // cycle 1
        chk("f1_s_arvalid", 32'(S_ARVALID), 32'd1);
        chk("f1_s_araddr", 32'(S_ARADDR), 32'h4);
        chk("f1_grant", 32'(GRANT), 32'b01);
        chk("f1_busy", 32'(BUSY), 32'd1);
        chk("f1_m0_arready", 32'(M0_ARREADY), 32'd0);
        tick(); // cycle 2
        chk("f2_s_rready", 32'(S_RREADY), 32'd1);
        chk("f2_s_arvalid", 32'(S_ARVALID), 32'd0);
        chk("f2_m0_rvalid", 32'(M0_RVALID), 32'd0);
        tick(); // cycle 3
        chk("f3_m0_arready", 32'(M0_ARREADY), 32'd1);
        chk("f3_m0_rvalid", 32'(M0_RVALID), 32'd1);
        chk("f3_m0_rdata", M0_RDATA, 32'h00500093);
        chk("f3_m1_rvalid", 32'(M1_RVALID), 32'd0);
        chk("f3_s_rready", 32'(S_RREADY), 32'd0);
        M0_ARVALID = 0;
        tick(); // cycle 4
        chk("f4_grant", 32'(GRANT), 32'd0);
        chk("f4_busy", 32'(BUSY), 32'd0);
        chk("f4_m0_rvalid", 32'(M0_RVALID), 32'd0);
        chk("f4_rdata_hold", M0_RDATA, 32'h00500093);

        // Slave wait states: ARREADY low for cycles 1-3, RVALID low for 5-6.
        S_ARREADY = 0; S_RVALID = 0; S_RDATA = 32'h12345678;
        M0_ARADDR = 4'h9; M0_ARVALID = 1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("w_s_arvalid", 32'(S_ARVALID), 32'd1);
            chk("w_s_araddr", 32'(S_ARADDR), 32'h9);
            M0_ARADDR = 4'(i); // changes after grant are ignored
        end
        tick(); // cycle 4
        chk("w4_s_arvalid", 32'(S_ARVALID), 32'd1);
        chk("w4_s_araddr", 32'(S_ARADDR), 32'h9);
        S_ARREADY = 1;
        tick(); // cycle 5
        chk("w5_s_rready", 32'(S_RREADY), 32'd1);
        chk("w5_s_arvalid", 32'(S_ARVALID), 32'd0);
        S_ARREADY = 0;
        tick(); // cycle 6
        chk("w6_m0_rvalid", 32'(M0_RVALID), 32'd0);
        tick(); // cycle 7
        chk("w7_m0_rvalid", 32'(M0_RVALID), 32'd0);
        chk("w7_s_rready", 32'(S_RREADY), 32'd1);
        S_RVALID = 1;
        tick(); // cycle 8
        chk("w8_m0_rvalid", 32'(M0_RVALID), 32'd1);
        chk("w8_m0_arready", 32'(M0_ARREADY), 32'd1);
        chk("w8_rdata", M0_RDATA, 32'h12345678);
        M0_ARVALID = 0;
        tick();
        chk("w9_busy", 32'(BUSY), 32'd0);

        // Simultaneous requests twice in a row, from a fresh reset.
        RST = 1;
        tick();
        RST = 0;
        S_ARREADY = 1; S_RVALID = 1; S_RDATA = 32'hCAFE0001;
        M0_ARADDR = 4'h1; M1_ARADDR = 4'h2;
        M0_ARVALID = 1; M1_ARVALID = 1; M0_RREADY = 1; M1_RREADY = 1;
        tick(); // cycle 1
        chk("t1_grant", 32'(GRANT), 32'(TieFirst));
        chk("t1_s_araddr", 32'(S_ARADDR), (TieFirst == 2'b01) ? 32'h1 : 32'h2);
        tick();
        tick(); // cycle 3
        chk("t1_m0_rvalid", 32'(M0_RVALID), 32'(TieFirst[0]));
        chk("t1_m1_rvalid", 32'(M1_RVALID), 32'(TieFirst[1]));
        tick(); // cycle 4: IDLE between transactions
        chk("t_gap_busy", 32'(BUSY), 32'd0);
        chk("t_gap_grant", 32'(GRANT), 32'd0);
        tick(); // cycle 5
        chk("t2_grant", 32'(GRANT), 32'(TieSecond));
        chk("t2_s_araddr", 32'(S_ARADDR), 32'h2);
        tick();
        tick(); // cycle 7
        chk("t2_m1_arready", 32'(M1_ARREADY), 32'd1);
        chk("t2_m0_arready", 32'(M0_ARREADY), 32'd0);
        M0_ARVALID = 0; M1_ARVALID = 0;
        tick();
        chk("t3_busy", 32'(BUSY), 32'd0);

        // Error response forwarded, then a fresh transaction with OKAY.
        S_RRESP = 2'b10; S_RDATA = 32'h0BAD0BAD;
        M0_ARADDR = 4'h3; M0_ARVALID = 1;
        tick(); tick(); tick();
        chk("e_m0_rvalid", 32'(M0_RVALID), 32'd1);
        chk("e_m0_rresp", 32'(M0_RRESP), 32'b10);
        M0_ARVALID = 0;
        tick();
        S_RRESP = 2'b00; S_RDATA = 32'h00000777; M0_ARVALID = 1;
        tick();
        chk("e2_grant", 32'(GRANT), 32'b01);
        chk("e2_rresp_held", 32'(M0_RRESP), 32'b10);
        tick(); tick();
        chk("e2_m0_rresp", 32'(M0_RRESP), 32'b00);
        chk("e2_m0_rdata", M0_RDATA, 32'h00000777);
        M0_ARVALID = 0;
        tick();

        // M1 abandons during DATA: response still taken from slave, one RESP cycle.
        S_RVALID = 0; S_RDATA = 32'h0000AB12;
        M1_ARADDR = 4'h7; M1_ARVALID = 1; M1_RREADY = 0;
        tick(); // cycle 1
        chk("a1_grant", 32'(GRANT), 32'b10);
        tick(); // cycle 2, DATA
        chk("a2_s_rready", 32'(S_RREADY), 32'd1);
        M1_ARVALID = 0; S_RVALID = 1;
        tick(); // cycle 3, RESP
        chk("a3_m1_rvalid", 32'(M1_RVALID), 32'd1);
        chk("a3_rdata", M1_RDATA, 32'h0000AB12);
        tick(); // cycle 4
        chk("a4_busy", 32'(BUSY), 32'd0);
        chk("a4_m1_rvalid", 32'(M1_RVALID), 32'd0);

        // M0 backpressure: RREADY low with ARVALID high holds RESP.
        M0_ARADDR = 4'h5; M0_ARVALID = 1; M0_RREADY = 0;
        tick(); tick(); tick(); // cycle 3
        chk("b3_m0_rvalid", 32'(M0_RVALID), 32'd1);
        tick(); tick(); // cycle 5
        chk("b5_m0_rvalid", 32'(M0_RVALID), 32'd1);
        chk("b5_busy", 32'(BUSY), 32'd1);
        chk("b5_grant", 32'(GRANT), 32'b01);
        M0_RREADY = 1; M0_ARVALID = 0;
        tick();
        chk("b6_busy", 32'(BUSY), 32'd0);

        // Reset in DATA.
        S_RVALID = 0; M0_ARADDR = 4'h6; M0_ARVALID = 1;
        tick(); tick(); // cycle 2, DATA
        chk("r2_s_rready", 32'(S_RREADY), 32'd1);
        RST = 1; M0_ARVALID = 0;
        tick();
        chk("r3_s_rready", 32'(S_RREADY), 32'd0);
        chk("r3_grant", 32'(GRANT), 32'd0);
        chk("r3_busy", 32'(BUSY), 32'd0);
        chk("r3_rdata", M0_RDATA, 32'hDEADBEEF);
        RST = 0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
